bootrom_axi_responder: RTL and testbench
========================================

Name: bootrom_axi_responder

Overview:
- AXI4 responder (subordinate) fronting the read-only boot ROM executable region (base 0x1_0000, length 0x10000).
- Serves core fetch and load bursts, including 2-beat icache line refills (128-bit line on a 64-bit bus).
- Drives a synchronous single-port ROM macro.
- Rejects all writes with SLVERR.
- Sits on the SoC crossbar behind the ATOP filter, so no AWATOP traffic ever reaches it.

Parameters:
- AxiIdWidth, 4, AXI ID width for AR/R/AW/B.
- AxiAddrWidth, 64, AXI address width.
- AxiDataWidth, 64, data width; only 64 is supported (elaboration assertion).
- RomBase, 64'h1_0000, region base byte address.
- RomByteSize, 64'h1_0000, region size in bytes; power of two, at least 8.
- RomAddrWidth, $clog2(RomByteSize/8), ROM word-address width (13 by default).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  AxiIdWidth  read ID
- ar_addr_i  in  AxiAddrWidth  read byte address
- ar_len_i  in  8  beats minus 1
- ar_size_i  in  3  log2 bytes per beat
- ar_burst_i  in  2  burst type: FIXED=0, INCR=1, WRAP=2
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  AxiIdWidth  read ID
- r_data_o  out  64  read data
- r_resp_o  out  2  OKAY=0, SLVERR=2
- r_last_o  out  1  last beat
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  AxiIdWidth  write ID
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  AxiIdWidth  write response ID
- b_resp_o  out  2  write response
- rom_req_o  out  1  ROM read strobe
- rom_addr_o  out  RomAddrWidth  ROM word address
- rom_rdata_i  in  64  ROM data; valid the cycle after rom_req_o, held until the next rom_req_o

Behaviour:
Reset:
- r_valid_o, b_valid_o, w_ready_o, rom_req_o = 0.
- All id, data, resp, last and rom_addr_o outputs = 0.
- ar_ready_o = 1 and aw_ready_o = 1 from the first cycle after reset release.
- Reset mid-burst discards the burst; no further beats are issued.

Read FSM, states R_IDLE, R_FETCH, R_DATA:
- R_IDLE: ar_ready_o=1. On AR handshake at cycle T, latch id, addr, len, size and burst; zero the beat counter.
- Error classification at T: SLVERR if (addr-RomBase) >= RomByteSize, or ar_size_i>3, or WRAP with len not in {1,3,7,15}. Error bursts skip R_FETCH and enter R_DATA with r_data_o=0.
- R_FETCH (T+1): rom_req_o=1, rom_addr_o=(addr-RomBase)>>3.
- R_DATA (first entered at T+2): r_valid_o=1, r_data_o=rom_rdata_i, r_resp_o per burst, r_last_o=(beat==len). The full 64-bit word is returned regardless of size.
- On r_ready_i in R_DATA: if last, go to R_IDLE (next AR accepted that cycle+1); otherwise advance the address and go to R_FETCH (or stay in R_DATA for error bursts).
- All R outputs remain stable while r_valid_o && !r_ready_i.
- Throughput is one beat per 2 cycles.
- Address advance:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~((1<<size)-1)) + (1<<size).
  - WRAP: wrap within an aligned window of (len+1)<<size bytes.
- An INCR burst that leaves the region mid-burst returns SLVERR, data 0, for the remaining beats; earlier beats stay OKAY.
- A burst always returns exactly len+1 beats.

Write FSM, states W_IDLE, W_DATA, W_RESP:
- W_IDLE: aw_ready_o=1; latch aw_id_i on handshake, go to W_DATA.
- W_DATA: w_ready_o=1; discard beats; on w_valid_i && w_last_i go to W_RESP.
- W_RESP: b_valid_o=1, b_resp_o=SLVERR, b_id_o=latched id; on b_ready_i go to W_IDLE.
- W beats arriving before AW are back-pressured (w_ready_o=0 outside W_DATA).
- The read and write FSMs are independent and may be active in the same cycle.

Optional Feature:
- Macro: BOOTROM_WRAP_BURST_EN.
- Defined: WRAP bursts are served as specified above.
- Undefined: any WRAP burst is classified as an error at AR handshake and returns len+1 SLVERR beats with data 0; no ROM access is made.

Test Plan:
- Reset, then AR id=3 addr=0x1_0000 len=0 size=3 INCR, ROM word0=0xDEADBEEF_CAFEF00D -> rom_req_o at T+1 with addr 0; R at T+2: id 3, data 0xDEADBEEF_CAFEF00D, OKAY, last=1.
- AR addr=0x1_0008 len=1 size=3 WRAP (macro defined) -> ROM addrs 1 then 0; two OKAY beats, last on the second. Macro undefined -> two SLVERR beats, data 0, no rom_req_o.
- AR addr=0x1_FFF8 len=1 INCR -> beat0 OKAY with ROM word 0x1FFF; beat1 SLVERR data 0, last=1.
- Hold r_ready_i=0 for 5 cycles on beat0 of a len=3 burst -> R outputs stable, no extra rom_req_o; 4 beats total.
- AW id=5 followed by 3 W beats (last on the third) -> w_ready_o high only after AW; B id=5 SLVERR. Concurrent AR is served unaffected.
- Assert rst_ni low during R_DATA of a len=7 burst -> r_valid_o=0 immediately; after release, ar_ready_o=1 and no stale beats appear.

Source files
------------

// File: rtl/bootrom_axi_responder.sv
// bootrom_axi_responder: AXI4 read-only responder for the boot ROM executable
// region. Reads are served from a synchronous single-port ROM macro at one
// beat per two cycles. All writes are drained and answered with SLVERR.
// Configuration macro: BOOTROM_WRAP_BURST_EN. When it is defined, WRAP bursts
// are served. When it is not defined, every WRAP burst is answered with SLVERR
// beats and no ROM access is made.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high. Once this block raises a valid, it
// holds that valid and every payload bit stable until that edge.
module bootrom_axi_responder #(
  parameter int          AxiIdWidth   = 4,
  parameter int          AxiAddrWidth = 64,
  parameter int          AxiDataWidth = 64,
  parameter logic [63:0] RomBase      = 64'h1_0000,
  parameter logic [63:0] RomByteSize  = 64'h1_0000,
  parameter int          RomAddrWidth = $clog2(RomByteSize / 8)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // read address channel
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  // read data channel
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [63:0]             r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  // write channels
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o,
  // ROM macro
  output logic                    rom_req_o,
  output logic [RomAddrWidth-1:0] rom_addr_o,
  input  logic [63:0]             rom_rdata_i
);

  if (AxiDataWidth != 64) begin : g_bad_data_width
    $error("bootrom_axi_responder: only AxiDataWidth = 64 is supported");
  end
  if ((RomByteSize < 64'd8) || ((RomByteSize & (RomByteSize - 64'd1)) != 64'd0)) begin : g_bad_rom_size
    $error("bootrom_axi_responder: RomByteSize must be a power of two of at least 8");
  end

  localparam logic [AxiAddrWidth-1:0] Base       = AxiAddrWidth'(RomBase);
  localparam logic [AxiAddrWidth-1:0] Size       = AxiAddrWidth'(RomByteSize);
  localparam logic [1:0]              RespOkay   = 2'd0;
  localparam logic [1:0]              RespSlverr = 2'd2;
  localparam logic [1:0]              BurstFixed = 2'd0;
  localparam logic [1:0]              BurstWrap  = 2'd2;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  r_state_e                r_state;
  w_state_e                w_state;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    burst_err_q;  // whole burst rejected at AR time
  logic                    beat_err_q;   // current beat carries SLVERR and zero data

  logic [AxiAddrWidth-1:0] ar_off;
  logic                    ar_err;
  logic [AxiAddrWidth-1:0] step;
  logic [AxiAddrWidth-1:0] incr_addr;
  logic [AxiAddrWidth-1:0] wrap_mask;
  logic [AxiAddrWidth-1:0] next_addr;
  logic [AxiAddrWidth-1:0] next_off;
  logic                    next_out;

  // Classify an incoming read burst as a whole-burst error.
  always_comb begin
    ar_off = ar_addr_i - Base;
    ar_err = (ar_off >= Size) || (ar_size_i > 3'd3);
    if (ar_burst_i == BurstWrap) begin
`ifdef BOOTROM_WRAP_BURST_EN
      if (!((ar_len_i == 8'd1) || (ar_len_i == 8'd3) ||
            (ar_len_i == 8'd7) || (ar_len_i == 8'd15))) begin
        ar_err = 1'b1;
      end
`else
      ar_err = 1'b1;
`endif
    end
  end

  // Next beat address. A WRAP burst stays inside an aligned window of
  // (len+1) << size bytes. An INCR burst realigns to the transfer size.
  always_comb begin
    step      = AxiAddrWidth'(1) << size_q;
    incr_addr = (addr_q & ~(step - 1'b1)) + step;
    wrap_mask = ((AxiAddrWidth'(len_q) + 1'b1) << size_q) - 1'b1;
    case (burst_q)
      BurstFixed: next_addr = addr_q;
      BurstWrap:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = incr_addr;
    endcase
    next_off = next_addr - Base;
    next_out = (next_off >= Size);
  end

  assign ar_ready_o = (r_state == R_IDLE);
  // ROM data is held until the next request, so it can be passed straight
  // through. It stays stable while the beat is stalled.
  assign r_data_o   = ((r_state == R_DATA) && !beat_err_q) ? rom_rdata_i : '0;

  // Read FSM: accept AR, then alternate a ROM fetch cycle and a data beat.
  // Error beats are presented back to back without touching the ROM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= R_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      burst_err_q <= 1'b0;
      beat_err_q  <= 1'b0;
      r_valid_o   <= 1'b0;
      r_id_o      <= '0;
      r_resp_o    <= RespOkay;
      r_last_o    <= 1'b0;
      rom_req_o   <= 1'b0;
      rom_addr_o  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_valid_i && ar_ready_o) begin
            r_id_o      <= ar_id_i;
            addr_q      <= ar_addr_i;
            len_q       <= ar_len_i;
            size_q      <= ar_size_i;
            burst_q     <= ar_burst_i;
            beat_q      <= 8'd0;
            burst_err_q <= ar_err;
            if (ar_err) begin
              r_state    <= R_DATA;
              r_valid_o  <= 1'b1;
              r_resp_o   <= RespSlverr;
              r_last_o   <= (ar_len_i == 8'd0);
              beat_err_q <= 1'b1;
            end else begin
              r_state    <= R_FETCH;
              rom_req_o  <= 1'b1;
              rom_addr_o <= ar_off[RomAddrWidth+2:3];
            end
          end
        end
        R_FETCH: begin
          r_state    <= R_DATA;
          rom_req_o  <= 1'b0;
          r_valid_o  <= 1'b1;
          r_resp_o   <= RespOkay;
          r_last_o   <= (beat_q == len_q);
          beat_err_q <= 1'b0;
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (r_last_o) begin
              r_state    <= R_IDLE;
              r_valid_o  <= 1'b0;
              r_last_o   <= 1'b0;
              r_resp_o   <= RespOkay;
              beat_err_q <= 1'b0;
            end else begin
              beat_q   <= beat_q + 8'd1;
              addr_q   <= next_addr;
              r_last_o <= (beat_q + 8'd1 == len_q);
              if (burst_err_q || next_out) begin
                r_resp_o   <= RespSlverr;
                beat_err_q <= 1'b1;
              end else begin
                r_state    <= R_FETCH;
                r_valid_o  <= 1'b0;
                rom_req_o  <= 1'b1;
                rom_addr_o <= next_off[RomAddrWidth+2:3];
              end
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign aw_ready_o = (w_state == W_IDLE);
  assign w_ready_o  = (w_state == W_DATA);
  assign b_valid_o  = (w_state == W_RESP);
  assign b_resp_o   = b_valid_o ? RespSlverr : RespOkay;

  // Write FSM: take AW, drain W beats up to the last one, answer SLVERR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      b_id_o  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_valid_i) begin
            b_id_o  <= aw_id_i;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i && w_last_i) w_state <= W_RESP;
        end
        W_RESP: begin
          if (b_ready_i) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bootrom_axi_responder.sv
// tb_bootrom_axi_responder: self-checking bench for bootrom_axi_responder.
// The reference model derives every beat address from the AXI burst rules
// and models ROM contents with a fixed function of the word address.
module tb_bootrom_axi_responder;

  localparam int          IdW  = 4;
  localparam int          RAW  = 13;
  localparam logic [63:0] Base = 64'h1_0000;
  localparam logic [63:0] Size = 64'h1_0000;
`ifdef BOOTROM_WRAP_BURST_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic           clk_i, rst_ni;
  logic           ar_valid_i, ar_ready_o;
  logic [IdW-1:0] ar_id_i;
  logic [63:0]    ar_addr_i;
  logic [7:0]     ar_len_i;
  logic [2:0]     ar_size_i;
  logic [1:0]     ar_burst_i;
  logic           r_valid_o, r_ready_i;
  logic [IdW-1:0] r_id_o;
  logic [63:0]    r_data_o;
  logic [1:0]     r_resp_o;
  logic           r_last_o;
  logic           aw_valid_i, aw_ready_o;
  logic [IdW-1:0] aw_id_i;
  logic           w_valid_i, w_ready_o, w_last_i;
  logic           b_valid_o, b_ready_i;
  logic [IdW-1:0] b_id_o;
  logic [1:0]     b_resp_o;
  logic           rom_req_o;
  logic [RAW-1:0] rom_addr_o;
  logic [63:0]    rom_rdata_i;

  int total;
  int bad;

  logic [RAW-1:0] rom_seen_q[$];
  logic [RAW-1:0] exp_rom_q[$];
  logic [63:0]    exp_q[$];
  logic [1:0]     exp_resp_q[$];

  bootrom_axi_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .b_resp_o(b_resp_o),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [63:0] rom_word(input logic [RAW-1:0] a);
    if (a == '0) return 64'hDEADBEEF_CAFEF00D;
    return {3'b101, a, 16'h5EED, ~{3'b000, a}, 16'h0F0F};
  endfunction

  // ROM macro model: data appears the cycle after a request and is held.
  always @(posedge clk_i) begin
    if (rom_req_o) rom_rdata_i <= rom_word(rom_addr_o);
  end

  // Record every ROM request seen.
  always @(negedge clk_i) begin
    if (rst_ni && rom_req_o) rom_seen_q.push_back(rom_addr_o);
  end

  // Reference model: expected beats and ROM word addresses for one burst.
  function automatic void build_expect(input logic [63:0] addr, input int len,
                                       input int size, input int burst);
    longint unsigned bytes, wbytes, aligned, lower, a, off;
    bit burst_err, wrap_ok;
    exp_q.delete();
    exp_resp_q.delete();
    exp_rom_q.delete();
    bytes   = 64'd1 << size;
    wbytes  = bytes * longint'(len + 1);
    aligned = addr / bytes * bytes;
    lower   = aligned / wbytes * wbytes;
    wrap_ok = WrapEn && (len == 1 || len == 3 || len == 7 || len == 15);
    burst_err = ((addr - Base) >= Size) || (size > 3) || (burst == 2 && !wrap_ok);
    for (int i = 0; i <= len; i++) begin
      if (i == 0 || burst == 0) a = addr;
      else if (burst == 2)      a = lower + ((aligned - lower + longint'(i) * bytes) % wbytes);
      else                      a = aligned + longint'(i) * bytes;
      off = a - Base;
      if (!burst_err && off < Size) begin
        exp_q.push_back(rom_word(off[15:3]));
        exp_resp_q.push_back(2'd0);
        exp_rom_q.push_back(off[15:3]);
      end else begin
        exp_q.push_back(64'd0);
        exp_resp_q.push_back(2'd2);
      end
    end
  endfunction

  // Driver + scoreboard for one read burst. hold0 forces that many stalled
  // cycles on beat 0; stall_pct adds random back-pressure afterwards.
  task automatic read_burst(input logic [IdW-1:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int stall_pct, input int hold0);
    logic [63:0]    d;
    logic [1:0]     rsp;
    logic [IdW+66:0] held;
    bit             have_held, rom_bad;
    int             beat, cyc, waited, held_cnt;
    build_expect(addr, int'(len), int'(size), int'(burst));
    rom_seen_q.delete();
    @(negedge clk_i);
    ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr;
    ar_len_i = len; ar_size_i = size; ar_burst_i = burst;
    waited = 0;
    while (!ar_ready_o && waited < 50) begin @(negedge clk_i); waited++; end
    total++;
    if (ar_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL ar_handshake: ar_ready_o=%b required 1 within 50 cycles", ar_ready_o);
      ar_valid_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    beat = 0; cyc = 0; have_held = 0; held_cnt = 0;
    while (beat <= int'(len) && cyc < 400) begin
      if (beat == 0 && held_cnt < hold0) r_ready_i = 1'b0;
      else r_ready_i = ($urandom_range(0, 99) >= stall_pct);
      if (r_valid_o) begin
        if (have_held) begin
          total++;
          if ({r_id_o, r_data_o, r_resp_o, r_last_o} !== held) begin
            bad++;
            $display("FAIL r_stable beat %0d: got %h required %h", beat,
                     {r_id_o, r_data_o, r_resp_o, r_last_o}, held);
          end
        end
        if (r_ready_i) begin
          d   = exp_q.pop_front();
          rsp = exp_resp_q.pop_front();
          total++;
          if (r_id_o !== id || r_data_o !== d || r_resp_o !== rsp ||
              r_last_o !== (beat == int'(len))) begin
            bad++;
            $display("FAIL r_beat %0d addr=%h: got id=%h data=%h resp=%0d last=%b required id=%h data=%h resp=%0d last=%b",
                     beat, addr, r_id_o, r_data_o, r_resp_o, r_last_o, id, d, rsp, (beat == int'(len)));
          end
          beat++;
          have_held = 0;
        end else begin
          held = {r_id_o, r_data_o, r_resp_o, r_last_o};
          have_held = 1;
          if (beat == 0) held_cnt++;
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    r_ready_i = 1'b0;
    total++;
    if (beat <= int'(len)) begin
      bad++;
      $display("FAIL r_beat_count: got %0d beats required %0d", beat, int'(len) + 1);
    end
    total++;
    if (r_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL r_extra_beat: r_valid_o=%b required 0 after last", r_valid_o);
    end
    rom_bad = (rom_seen_q.size() != exp_rom_q.size());
    if (!rom_bad) begin
      for (int i = 0; i < exp_rom_q.size(); i++)
        if (rom_seen_q[i] !== exp_rom_q[i]) rom_bad = 1;
    end
    total++;
    if (rom_bad) begin
      bad++;
      $display("FAIL rom_seq addr=%h: got %0d requests first=%h required %0d first=%h", addr,
               rom_seen_q.size(), (rom_seen_q.size() > 0) ? rom_seen_q[0] : '0,
               exp_rom_q.size(), (exp_rom_q.size() > 0) ? exp_rom_q[0] : '0);
    end
  endtask

  // Driver for one write burst with W offered before AW.
  task automatic test_write(input logic [IdW-1:0] id, input int nbeats);
    int n;
    @(negedge clk_i);
    w_valid_i = 1'b1; w_last_i = 1'b0;
    repeat (2) begin
      total++;
      if (w_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL w_ready_before_aw: got %b required 0", w_ready_o);
      end
      @(negedge clk_i);
    end
    aw_valid_i = 1'b1; aw_id_i = id;
    total++;
    if (aw_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL aw_ready: got %b required 1", aw_ready_o);
    end
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      w_last_i = (i == nbeats - 1);
      n = 0;
      while (!w_ready_o && n < 20) begin @(negedge clk_i); n++; end
      total++;
      if (w_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL w_ready beat %0d: got %b required 1", i, w_ready_o);
      end
      @(negedge clk_i);
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    repeat (2) begin
      total++;
      if ({w_ready_o, b_valid_o, b_id_o, b_resp_o} !== {1'b0, 1'b1, id, 2'd2}) begin
        bad++;
        $display("FAIL b_resp: got w_ready=%b b_valid=%b id=%h resp=%0d required 0 1 %h 2",
                 w_ready_o, b_valid_o, b_id_o, b_resp_o, id);
      end
      @(negedge clk_i);
    end
    b_ready_i = 1'b1;
    @(negedge clk_i);
    b_ready_i = 1'b0;
    total++;
    if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b_done: got b_valid=%b aw_ready=%b required 0 1", b_valid_o, aw_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    r_ready_i = 0; aw_valid_i = 0; aw_id_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({r_valid_o, b_valid_o, w_ready_o, rom_req_o, r_id_o, r_data_o, r_resp_o,
         r_last_o, b_id_o, b_resp_o, rom_addr_o} !== '0) begin
      bad++;
      $display("FAIL reset_values: r_valid=%b b_valid=%b w_ready=%b rom_req=%b r_data=%h rom_addr=%h required all 0",
               r_valid_o, b_valid_o, w_ready_o, rom_req_o, r_data_o, rom_addr_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if (ar_ready_o !== 1'b1 || aw_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: ar_ready=%b aw_ready=%b required 1 1", ar_ready_o, aw_ready_o);
    end
  endtask

  // First read with exact cycle timing: ROM request at T+1, data at T+2.
  task automatic test_first_read();
    @(negedge clk_i);
    ar_valid_i = 1'b1; ar_id_i = 4'd3; ar_addr_i = Base; ar_len_i = 8'd0;
    ar_size_i = 3'd3; ar_burst_i = 2'd1; r_ready_i = 1'b0;
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    total++;
    if ({rom_req_o, rom_addr_o, r_valid_o} !== {1'b1, 13'd0, 1'b0}) begin
      bad++;
      $display("FAIL first_fetch: rom_req=%b rom_addr=%h r_valid=%b required 1 0 0",
               rom_req_o, rom_addr_o, r_valid_o);
    end
    @(negedge clk_i);
    total++;
    if (r_valid_o !== 1'b1 || rom_req_o !== 1'b0 || r_id_o !== 4'd3 ||
        r_data_o !== 64'hDEADBEEF_CAFEF00D || r_resp_o !== 2'd0 || r_last_o !== 1'b1) begin
      bad++;
      $display("FAIL first_beat: valid=%b id=%h data=%h resp=%0d last=%b required 1 3 deadbeefcafef00d 0 1",
               r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o);
    end
    r_ready_i = 1'b1;
    @(negedge clk_i);
    r_ready_i = 1'b0;
    total++;
    if (r_valid_o !== 1'b0 || ar_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL first_done: r_valid=%b ar_ready=%b required 0 1", r_valid_o, ar_ready_o);
    end
  endtask

  task automatic test_directed_bursts();
    read_burst(4'h1, Base + 64'h8, 8'd1, 3'd3, 2'd2, 0, 0);          // 2-beat wrap refill
    read_burst(4'h2, Base + Size - 64'h8, 8'd1, 3'd3, 2'd1, 0, 0);   // leaves region
    read_burst(4'h4, Base + 64'h20, 8'd2, 3'd3, 2'd0, 20, 0);        // fixed
    read_burst(4'h5, Base + 64'h40, 8'd2, 3'd4, 2'd1, 0, 0);         // size too large
    read_burst(4'hA, Base - 64'h8, 8'd3, 3'd3, 2'd1, 0, 0);          // starts below region
  endtask

  task automatic test_stall();
    read_burst(4'h6, Base + 64'h200, 8'd3, 3'd3, 2'd1, 0, 5);
  endtask

  task automatic test_concurrent_write();
    fork
      test_write(4'd5, 3);
      read_burst(4'h9, Base + 64'h100, 8'd3, 3'd3, 2'd1, 30, 0);
    join
  endtask

  task automatic test_reset_mid_burst();
    int n;
    bit stale;
    @(negedge clk_i);
    ar_valid_i = 1'b1; ar_id_i = 4'd7; ar_addr_i = Base + 64'h40; ar_len_i = 8'd7;
    ar_size_i = 3'd3; ar_burst_i = 2'd1; r_ready_i = 1'b0;
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    n = 0;
    while (!r_valid_o && n < 10) begin @(negedge clk_i); n++; end
    total++;
    if (r_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_setup: r_valid=%b required 1", r_valid_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({r_valid_o, rom_req_o, r_last_o, r_resp_o, r_id_o, r_data_o} !== '0) begin
      bad++;
      $display("FAIL mid_reset_clear: r_valid=%b rom_req=%b data=%h required 0 0 0",
               r_valid_o, rom_req_o, r_data_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if (ar_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_ready: ar_ready=%b required 1", ar_ready_o);
    end
    r_ready_i = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (r_valid_o || rom_req_o) stale = 1;
    end
    r_ready_i = 1'b0;
    total++;
    if (stale) begin
      bad++;
      $display("FAIL mid_reset_stale: saw r_valid or rom_req after reset, required none");
    end
  endtask

  task automatic test_random();
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    for (int k = 0; k < 40; k++) begin
      burst = 2'($urandom_range(0, 2));
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if (burst == 2'd2) begin
        case ($urandom_range(0, 4))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          3: len = 8'd15;
          default: len = 8'd2;
        endcase
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      case ($urandom_range(0, 9))
        0: addr = Base - 64'($urandom_range(1, 64));
        1: addr = Base + Size + 64'($urandom_range(0, 64));
        2, 3: addr = Base + Size - 64'(8 * $urandom_range(1, 6)) + 64'($urandom_range(0, 7));
        default: addr = Base + 64'($urandom_range(0, 16'hFFFF));
      endcase
      read_burst(4'($urandom_range(0, 15)), addr, len, size, burst, $urandom_range(0, 60), 0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_first_read();
    test_directed_bursts();
    test_stall();
    test_concurrent_write();
    test_reset_mid_burst();
    test_random();
    test_write(4'd12, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
